// File: rtl/endec_axis_host_pkg.sv
// Shared constants and types for the convolutional codec AXI4-Stream host.
// Holds the job geometry (polynomial width, beat count), the config-beat
// layout, the error code encodings and the host FSM state type.
package endec_axis_host_pkg;

  localparam int unsigned MAX_CONSTRAINT_LENGTH = 9;
  localparam int unsigned MAX_CODE_RATE         = 3;
  localparam int unsigned POLY_W                = MAX_CONSTRAINT_LENGTH * MAX_CODE_RATE;

  // Both the request data packet and the result packet are this many beats.
  localparam int unsigned BEAT_COUNT    = 8;
  // Config beat layout: polynomials in the low bits, code rate above them.
  localparam int unsigned CONF_RATE_BIT = 27;

  localparam int unsigned ENC_IN_W  = 128;
  localparam int unsigned DEC_IN_W  = 384;
  localparam int unsigned ENC_OUT_W = 384;
  localparam int unsigned DEC_OUT_W = 128;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_LONG    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StTxConf,
    StTxData,
    StRxResp,
    StDrain,
    StDone
  } state_t;

endpackage

// File: rtl/endec_resp_timer.sv
// Result-stream idle timer.
// Counts cycles while count_en is high and clear is low; saturates at
// RESP_TIMEOUT and raises expired while the count sits there.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : synchronous return to zero (wins over count_en)
//   count_en  : advance the count this cycle
//   expired   : count has reached RESP_TIMEOUT
module endec_resp_timer #(
  parameter int unsigned RESP_TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(RESP_TIMEOUT + 1);

  logic [CntW-1:0] count_q;

  assign expired = (count_q == CntW'(RESP_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/endec_axis_host.sv
// Host-side AXI4-Stream initiator for the convolutional codec wrapper.
// Takes one job on a parallel port, sends a 1-beat config packet and an
// 8-beat data packet on m_axis, collects the 8-beat result packet on s_axis
// and presents encoded/decoded data with a one-cycle o_done pulse.
//   sys_clk, rst                : clock, asynchronous active-high reset
//   i_start + i_* job inputs    : job request, sampled only while o_busy=0
//   m_axis_*                    : request stream (config, then data)
//   s_axis_*                    : result stream
//   o_encoder_data/o_decoder_data, o_err, o_err_code : results, held until next o_done
//   o_busy, o_done              : job in progress / job finished pulse
module endec_axis_host
  import endec_axis_host_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned RESP_TIMEOUT = 65535
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_code_rate,
  input  logic [POLY_W-1:0]    i_gen_poly_flat,
  input  logic [ENC_IN_W-1:0]  i_encoder_data_frame,
  input  logic [DEC_IN_W-1:0]  i_decoder_data_frame,
  output logic                 o_busy,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [ENC_OUT_W-1:0] o_encoder_data,
  output logic [DEC_OUT_W-1:0] o_decoder_data,
  output logic                 o_done,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);

  localparam int unsigned FrameW = BEAT_COUNT * DATA_W;

  state_t              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [FrameW-1:0]   pay_q, pay_d;    // outgoing payload, current beat at the top
  logic [FrameW-1:0]   resp_q, resp_d;  // result packet, filled MSB-first
  logic [1:0]          code_q, code_d;  // error code of the job in flight
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tlast_q, tlast_d;
  logic                tvalid_q, tready_q, busy_q, done_q, err_q;
  logic [1:0]          err_code_q;
  logic [ENC_OUT_W-1:0] enc_q;
  logic [DEC_OUT_W-1:0] dec_q;
  logic                start_job, finish;
  logic                m_hs, s_hs, expired;

  assign m_hs = tvalid_q & m_axis_tready;
  assign s_hs = tready_q & s_axis_tvalid;

  endec_resp_timer #(
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) u_resp_timer (
    .clk      (sys_clk),
    .rst      (rst),
    .clear    ((state_q != StRxResp) || s_hs),
    .count_en (state_q == StRxResp),
    .expired  (expired)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pay_d     = pay_q;
    resp_d    = resp_q;
    code_d    = code_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    start_job = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // DONE already has o_busy low, so a new job can start right there.
        if (state_q == StDone) state_d = StIdle;
        if (i_start) begin
          start_job = 1'b1;
          state_d   = StTxConf;
          pay_d     = {i_decoder_data_frame, i_encoder_data_frame};
          resp_d    = '0;
          code_d    = ERR_NONE;
          beat_d    = '0;
          tdata_d   = '0;
          tdata_d[POLY_W-1:0]   = i_gen_poly_flat;
          tdata_d[CONF_RATE_BIT] = i_code_rate;
          tlast_d   = 1'b1;
        end
      end
      StTxConf: begin
        if (m_hs) begin
          state_d = StTxData;
          beat_d  = '0;
          tdata_d = pay_q[FrameW-1 -: DATA_W];
          tlast_d = 1'b0;
        end
      end
      StTxData: begin
        if (m_hs) begin
          pay_d   = pay_q << DATA_W;
          tdata_d = pay_d[FrameW-1 -: DATA_W];
          tlast_d = (beat_q == 3'd6);
          if (beat_q == 3'd7) begin
            state_d = StRxResp;
            beat_d  = '0;
            tlast_d = 1'b0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      StRxResp: begin
        if (s_hs) begin
          resp_d[(3'd7 - beat_q) * DATA_W +: DATA_W] = s_axis_tdata;
          if (s_axis_tlast) begin
            finish  = 1'b1;
            state_d = StDone;
            code_d  = (beat_q == 3'd7) ? ERR_NONE : ERR_SHORT;
          end else if (beat_q == 3'd7) begin
            state_d = StDrain;
            code_d  = ERR_LONG;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end else if (expired) begin
          finish  = 1'b1;
          state_d = StDone;
          code_d  = ERR_TIMEOUT;
        end
      end
      StDrain: begin
        if (s_hs && s_axis_tlast) begin
          finish  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      beat_q     <= '0;
      pay_q      <= '0;
      resp_q     <= '0;
      code_q     <= ERR_NONE;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      enc_q      <= '0;
      dec_q      <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pay_q    <= pay_d;
      resp_q   <= resp_d;
      code_q   <= code_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      // Stream/status flags are flopped from the next state so they are
      // glitch-free and independent of the same-cycle ready inputs.
      tvalid_q <= (state_d == StTxConf) || (state_d == StTxData);
      tready_q <= (state_d == StRxResp) || (state_d == StDrain);
      busy_q   <= (state_d != StIdle) && (state_d != StDone);
      done_q   <= finish;
      if (start_job) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end
      if (finish) begin
        enc_q      <= resp_d[ENC_OUT_W-1:0];
        dec_q      <= resp_d[FrameW-1 -: DEC_OUT_W];
        err_q      <= (code_d != ERR_NONE);
        err_code_q <= code_d;
      end
    end
  end

  assign o_busy         = busy_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign s_axis_tready  = tready_q;
  assign o_encoder_data = enc_q;
  assign o_decoder_data = dec_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_err_code     = err_code_q;

endmodule

// File: doc/endec_axis_host.md
# endec_axis_host

Host-side AXI4-Stream initiator for the convolutional encoder/decoder core's streaming wrapper. Accepts one job (code rate, generator polynomials, encoder frame, decoder frame) on a parallel port, sends it as a 1-beat config packet plus an 8-beat data packet, then collects the 8-beat result packet and presents the encoded/decoded data in parallel. It sits between the system controller and the codec's AXI-stream slave/master pair.

## Interface
- DATA_W, 64, stream beat width
- RESP_TIMEOUT, 65535, max idle cycles between result beats before abort (≥2)

- sys_clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  job request; accepted only while o_busy=0
- i_code_rate  in  1  0 = rate 1/2, 1 = rate 1/3
- i_gen_poly_flat  in  `MAX_CONSTRAINT_LENGTH*`MAX_CODE_RATE  generator polynomials
- i_encoder_data_frame  in  128  bits to encode
- i_decoder_data_frame  in  384  symbols to decode
- o_busy  out  1  job in progress
- m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  64/1/1  request stream
- m_axis_tready  in  1
- s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  64/1/1  result stream
- s_axis_tready  out  1
- o_encoder_data  out  384  encoded result
- o_decoder_data  out  128  decoded result
- o_done  out  1  one-cycle pulse, results/error valid
- o_err  out  1  job ended abnormally
- o_err_code  out  2  00 none, 01 short packet, 10 long packet, 11 timeout

## Operation
- States: IDLE, TX_CONF, TX_DATA, RX_RESP, DRAIN, DONE.
- IDLE: o_busy=0, s_axis_tready=0. On i_start, register all job inputs, clear o_err/o_err_code, go to TX_CONF.
- TX_CONF: one beat, tdata[26:0]=gen_poly_flat, tdata[27]=code_rate, tdata[63:28]=0, tlast=1. On handshake go to TX_DATA, beat counter=0.
- TX_DATA: payload P = {decoder_frame, encoder_frame} (512 b), sent MSB-first: beat k carries P[511-64k -: 64]; tlast=1 only on beat 7. After beat 7 handshake go to RX_RESP.
- RX_RESP: s_axis_tready=1. Beat k stored into R[511-64k -: 64]; R = {decoder_data[127:0], encoder_data[383:0]}.
  - tlast on beat 7: DONE, no error.
  - tlast on beat k<7: DONE, err 01; outputs updated with the partial R (unreceived bits 0).
  - beat 7 without tlast: DRAIN, err 10.
  - RESP_TIMEOUT consecutive cycles without handshake: DONE, err 11.
- DRAIN: s_axis_tready=1, discard beats until a beat with tlast, then DONE.
- DONE: o_done=1 for one cycle, o_encoder_data/o_decoder_data/o_err/o_err_code loaded; go to IDLE. Outputs hold until next DONE.
- i_start while busy: ignored (no queueing). s_axis traffic in IDLE/TX_*: not accepted (tready=0).

## Timing
- All outputs registered. Reset values: all outputs 0, state IDLE, counters 0.
- AXI rules: m_axis_tvalid never depends on m_axis_tready; once asserted, tdata/tlast/tvalid stay stable until handshake. Beat transfers on tvalid&tready at rising edge.
- tvalid asserts the cycle after i_start is sampled; with tready held high, config at cycle 1, data beats cycles 2–9, one beat per cycle, no bubbles.
- s_axis_tready asserts the cycle after the last data handshake (cycle 10 min); one result beat per cycle accepted.
- Min start-to-o_done latency: 18 cycles (8 result beats at cycles 10–17, o_done at 18); o_busy falls with o_done, new i_start accepted the same cycle o_busy is 0.
- Timeout counter: counts cycles in RX_RESP with no handshake, cleared on every handshake; reaching RESP_TIMEOUT triggers abort next edge. Not active in TX states (tready backpressure may be unbounded).
- rst mid-job: immediate return to IDLE, tvalid/tready/done drop asynchronously, partial results discarded, outputs cleared.

## Structure
- Add to param_def.sv: beat count (8), config bit positions (code rate bit 27), error code constants, state encodings.
- One natural sub-module: endec_resp_timer (load/clear, count, expire flag, parameter RESP_TIMEOUT). Serializer/deserializer shift logic stays in the top.

## Test plan
- Rate 1/2 job, tready always 1, responder echoes 8 beats with tlast on 8th -> tvalid cycles 1–9, config tdata[27]=0, o_done at cycle 18, results match echoed P, err 00.
- Random m_axis_tready backpressure (50%) -> tdata/tlast stable while tvalid&!tready, all 9 beats in order, tlast only on beats 1 and 9.
- Responder sends tlast on 5th beat -> o_done, o_err=1, code 01, encoder_data low 192 bits 0.
- Responder sends 10 beats, tlast on 10th -> 2 beats drained, o_done after 10th, code 10.
- Responder silent with RESP_TIMEOUT=20 -> o_done 21 cycles after RX_RESP entry, code 11, s_axis_tready=0 afterward.
- rst pulse during TX_DATA beat 4 -> all outputs 0 immediately; following job completes normally.
